// File: rtl/arb_mux_nto1.sv
// rtl/arb_mux_nto1.sv - N-to-1 registered mux with round-robin arbitration (ARB_MUX_FIXED_PRIO_EN selects fixed priority)
module arb_mux_nto1 #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [N*WIDTH-1:0]   inData,
    input  logic [N-1:0]         inValid,
    output logic [N-1:0]         inReady,
    output logic [WIDTH-1:0]     outData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [SELW-1:0]      outSel
);

    logic [WIDTH-1:0] chan [N];
    logic [SELW-1:0]  start;
    logic [SELW-1:0]  grant;
    logic [SELW:0]    sum;
    logic             found;
    logic             load;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign chan[i] = inData[i*WIDTH +: WIDTH];
    end

`ifdef ARB_MUX_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [SELW-1:0] ptr;
    assign start = ptr;
`endif

    assign load = !outValid || outReady;

    // Search start, start+1, ... wrapping at N; sum carries one extra bit so the wrap test is exact.
    always_comb begin
        found = 1'b0;
        grant = '0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, start} + (SELW+1)'(k);
            if (sum >= (SELW+1)'(N)) begin
                sum = sum - (SELW+1)'(N);
            end
            if (!found && inValid[sum[SELW-1:0]]) begin
                found = 1'b1;
                grant = sum[SELW-1:0];
            end
        end
    end

    always_comb begin
        inReady = '0;
        if (found && load && !Rst) begin
            inReady[grant] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            outData  <= '0;
            outSel   <= '0;
            outValid <= 1'b0;
        end else if (found && load) begin
            outData  <= chan[grant];
            outSel   <= grant;
            outValid <= 1'b1;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

`ifndef ARB_MUX_FIXED_PRIO_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ptr <= '0;
        end else if (found && load) begin
            ptr <= (grant == SELW'(N-1)) ? '0 : grant + SELW'(1);
        end
    end
`endif

endmodule

// File: doc/arb_mux_nto1.md
# arb_mux_nto1

Parametrised N-to-1, WIDTH-bit multiplexer with a registered output stage and valid/ready handshaking on every port. Channel selection is made by a round-robin arbiter, not an external select line. The block merges several producers onto one datapath, for example competing memory or writeback requests in the MIPS pipeline. It sustains one transfer per cycle with one cycle of latency.

## Interface
- WIDTH, 32: data width per channel, ≥1.
- N, 4: channel count, 2..16.
- SELW, $clog2(N): width of the channel index (localparam).

Ports (clock and reset first):
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- inData  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- inValid  input  N  channel i presents valid data.
- inReady  output  N  channel i's data is accepted this cycle (combinational).
- outData  output  WIDTH  registered output data.
- outValid  output  1  outData holds a valid entry.
- outReady  input  1  the consumer accepts outData this cycle.
- outSel  output  SELW  index of the channel that supplied the current outData.

## Operation
- **Storage.** The block has a single output register: outData, outSel and outValid.
- **Load enable.** load = !outValid | outReady. The register can accept a new entry when it is empty or is being drained this cycle.
- **Arbitration.** The arbiter searches channels in the order ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N). The first channel with inValid=1 wins and becomes g.
- **Grant.** inReady[g] = load & inValid[g] & !Rst. All other inReady bits are 0. At most one bit of inReady is 1, and inReady is never 1 for a channel whose inValid is 0.
- **Transfer.** On a rising edge with inValid[g] & inReady[g]:
  - outData ← channel g data
  - outSel ← g
  - outValid ← 1
  - ptr ← (g+1) mod N. When g = N-1, ptr wraps to 0.
- **Drain without refill.** If outValid & outReady and no channel is valid, outValid ← 0. outData and outSel hold their values.
- **Stall.** If outValid & !outReady, all inReady bits are 0, and outData, outSel and ptr are held unchanged.
- **Simultaneous drain and refill.** This is one edge: the old entry leaves and the new entry loads. No bubble is inserted.
- **Stable inputs required.** Producers must hold inData and inValid stable until inReady is seen. The block does not latch them early.
- **Pointer width.** ptr is SELW bits. When N is not a power of two, the increment compares against N-1 and wraps explicitly.

## Timing
- **Reset values.** Rst=1 forces outValid=0, outData=0, outSel=0 and ptr=0 immediately, without waiting for a clock edge. inReady is 0 while Rst=1.
- **Reset mid-transfer.** The in-flight entry is discarded.
- **Latency.** An input accepted at edge k appears on outData/outValid just after edge k. It is therefore visible to the consumer in cycle k+1.
- **Throughput.** One transfer per cycle while outReady=1 and at least one channel is valid.
- **Combinational paths.** outReady → inReady and inValid → inReady. There is no combinational path from inData to any output.
- **Fairness.** With all N channels continuously valid and outReady=1, each channel is granted exactly once every N cycles.

## Configuration
- Macro: ARB_MUX_FIXED_PRIO_EN.
- **Defined:** fixed priority, lowest index wins. ptr is removed and the search always starts at channel 0. All other behaviour is unchanged.
- **Undefined (default):** round-robin as described in Operation.

## Test plan
All scenarios use WIDTH=32 and N=4.
- **Reset.** Assert Rst=1 asynchronously while outValid=1 and outData=0x12345678 → outValid=0, outData=0, outSel=0 before the next edge, and inReady=4'b0000 while Rst is high.
- **Single channel.** After reset, inValid=4'b0100, channel 2 data=0xDEADBEEF, outReady=1 → inReady=4'b0100 in the same cycle. After the next edge: outValid=1, outData=0xDEADBEEF, outSel=2.
- **Round-robin.** All inValid=1, channel i data=0xA0+i, outReady=1 for 8 cycles after reset → outSel sequence 0,1,2,3,0,1,2,3 and outData 0xA0,0xA1,0xA2,0xA3,… with no bubbles.
- **Backpressure.** outValid=1, outData=0xA1, outReady=0 for 5 cycles with all channels valid → inReady=0 and outData=0xA1 held throughout. On the cycle outReady rises, inReady=4'b0100 (ptr=2) and outSel=2 after the edge.
- **Wrap and drain.** After a grant to channel 3 (ptr=0), inValid=4'b0011 → grants 0, then 1. Then inValid=0 with outReady=1 → outValid=0 one edge later, with outData holding channel 1's value.
- **Fixed priority.** Build with ARB_MUX_FIXED_PRIO_EN, all channels valid, outReady=1 → outSel=0 on every cycle.
